// File: rtl/vga_timing_pkg.sv
// Default 640x480@60 raster constants and the coordinate type shared by
// the timing generator and its counters.
package vga_timing_pkg;

    localparam int H_VISIBLE_DEF = 640;
    localparam int H_FRONT_DEF   = 16;
    localparam int H_SYNC_DEF    = 96;
    localparam int H_BACK_DEF    = 48;
    localparam int V_VISIBLE_DEF = 480;
    localparam int V_FRONT_DEF   = 10;
    localparam int V_SYNC_DEF    = 2;
    localparam int V_BACK_DEF    = 33;

    localparam int H_TOTAL_DEF = H_VISIBLE_DEF + H_FRONT_DEF + H_SYNC_DEF + H_BACK_DEF;
    localparam int V_TOTAL_DEF = V_VISIBLE_DEF + V_FRONT_DEF + V_SYNC_DEF + V_BACK_DEF;

    localparam int COORD_W = 10;
    typedef logic [COORD_W-1:0] coord_t;

endpackage

// File: rtl/vga_axis_counter.sv
// Wrap-at-limit counter for one raster axis. Exposes the next value so the
// parent can register decoded outputs in step with the count itself.
module vga_axis_counter
    import vga_timing_pkg::*;
#(
    parameter int LIMIT = H_TOTAL_DEF
) (
    input  logic   clk,
    input  logic   rst_n,
    input  logic   en,
    output coord_t count,
    output coord_t count_next,
    output logic   carry
);

    localparam coord_t LAST = coord_t'(LIMIT - 1);

    always_comb begin
        carry      = en && (count == LAST);
        count_next = count;
        if (en) begin
            count_next = (count == LAST) ? '0 : count + coord_t'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else begin
            count <= count_next;
        end
    end

endmodule

// File: rtl/vga_timing_gen.sv
// VGA raster timing: coordinates, active-low syncs, display enable, frame and
// vblank strobes, and a frame counter, all registered with zero relative skew.
module vga_timing_gen
    import vga_timing_pkg::*;
#(
    parameter int H_VISIBLE = H_VISIBLE_DEF,
    parameter int H_FRONT   = H_FRONT_DEF,
    parameter int H_SYNC    = H_SYNC_DEF,
    parameter int H_BACK    = H_BACK_DEF,
    parameter int V_VISIBLE = V_VISIBLE_DEF,
    parameter int V_FRONT   = V_FRONT_DEF,
    parameter int V_SYNC    = V_SYNC_DEF,
    parameter int V_BACK    = V_BACK_DEF
) (
    input  logic       vga_clk,
    input  logic       reset_n,
    output logic [9:0] DrawX,
    output logic [9:0] DrawY,
    output logic       hs,
    output logic       vs,
    output logic       blank,
    output logic       frame_start,
    output logic       vblank_start,
    output logic [7:0] frame_count
);

    localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

    generate
        if (H_TOTAL > 1024 || V_TOTAL > 1024) begin : g_range_check
            $error("vga_timing_gen: raster totals must fit 10-bit counters");
        end
    endgenerate

    localparam coord_t HS_START = coord_t'(H_VISIBLE + H_FRONT);
    localparam coord_t HS_END   = coord_t'(H_VISIBLE + H_FRONT + H_SYNC);
    localparam coord_t VS_START = coord_t'(V_VISIBLE + V_FRONT);
    localparam coord_t VS_END   = coord_t'(V_VISIBLE + V_FRONT + V_SYNC);
    localparam coord_t H_VIS    = coord_t'(H_VISIBLE);
    localparam coord_t V_VIS    = coord_t'(V_VISIBLE);

    coord_t h_count, h_next, v_count, v_next;
    logic   h_carry, v_carry;

    vga_axis_counter #(.LIMIT(H_TOTAL)) u_h_counter (
        .clk        (vga_clk),
        .rst_n      (reset_n),
        .en         (1'b1),
        .count      (h_count),
        .count_next (h_next),
        .carry      (h_carry)
    );

    vga_axis_counter #(.LIMIT(V_TOTAL)) u_v_counter (
        .clk        (vga_clk),
        .rst_n      (reset_n),
        .en         (h_carry),
        .count      (v_count),
        .count_next (v_next),
        .carry      (v_carry)
    );

    assign DrawX = h_count;
    assign DrawY = v_count;

    // Decode from the next coordinates so each registered flag lands together
    // with the pixel it describes.
    always_ff @(posedge vga_clk or negedge reset_n) begin
        if (!reset_n) begin
            hs           <= 1'b1;
            vs           <= 1'b1;
            blank        <= 1'b1;
            frame_start  <= 1'b1;
            vblank_start <= 1'b0;
            frame_count  <= 8'd0;
        end else begin
            hs           <= !((h_next >= HS_START) && (h_next < HS_END));
            vs           <= !((v_next >= VS_START) && (v_next < VS_END));
            blank        <= (h_next < H_VIS) && (v_next < V_VIS);
            frame_start  <= (h_next == '0) && (v_next == '0);
            vblank_start <= (h_next == '0) && (v_next == V_VIS);
            if (h_carry && v_carry) begin
                frame_count <= frame_count + 8'd1;
            end
        end
    end

endmodule
